// File: rtl/axil_reg_slave.sv
// AXI4-Lite responder with three read/write registers and a read-only count of
// accepted writes. Bad addresses and writes to the counter answer SLVERR.
module axil_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int BASE_ADDR  = 0
) (
  input  logic                    s0_axi_aclk,
  input  logic                    s0_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s0_axi_wstrb,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic [RESP_WIDTH-1:0]   s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s0_axi_rresp,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] BASE        = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  localparam logic [1:0] W_IDLE      = 2'd0;
  localparam logic [1:0] W_HAVE_ADDR = 2'd1;
  localparam logic [1:0] W_HAVE_DATA = 2'd2;
  localparam logic [1:0] W_RESP      = 2'd3;
  localparam logic [0:0] R_IDLE      = 1'b0;
  localparam logic [0:0] R_DATA      = 1'b1;

  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [NB-1:0]         strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < NB; b++)
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    return res;
  endfunction

  // rf[3] is the write counter; rf[0..2] are the general registers.
  logic [DATA_WIDTH-1:0] rf [4];

  logic [1:0]            w_state, w_nxt;
  logic [ADDR_WIDTH-1:0] awaddr_q, w_addr;
  logic [DATA_WIDTH-1:0] wdata_q, w_data;
  logic [NB-1:0]         wstrb_q, w_strb;
  logic                  aw_hs, w_hs, commit, w_ok;
  logic [ADDR_WIDTH:0]   w_diff;
  logic [1:0]            w_idx;
  logic                  unused_strb_msb;

  logic [0:0]            r_state, r_nxt;
  logic                  ar_hs, r_ok;
  logic [ADDR_WIDTH:0]   r_diff;
  logic [1:0]            r_idx;

  assign unused_strb_msb = s0_axi_wstrb[NB];

  assign aw_hs = s0_axi_awvalid & s0_axi_awready;
  assign w_hs  = s0_axi_wvalid & s0_axi_wready;

  // A handshake on the committing edge bypasses the holding register.
  always_comb begin
    w_addr = aw_hs ? s0_axi_awaddr : awaddr_q;
    w_data = w_hs ? s0_axi_wdata : wdata_q;
    w_strb = w_hs ? s0_axi_wstrb[NB-1:0] : wstrb_q;
    w_diff = {1'b0, w_addr} - {1'b0, BASE};
    w_idx  = w_diff[3:2];
    w_ok   = !w_diff[ADDR_WIDTH] && (w_diff[ADDR_WIDTH-1:4] == '0) &&
             (w_diff[1:0] == 2'b00) && (w_idx != 2'd3);
  end

  always_comb begin
    w_nxt = w_state;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs)  w_nxt = W_RESP;
        else if (aw_hs)     w_nxt = W_HAVE_ADDR;
        else if (w_hs)      w_nxt = W_HAVE_DATA;
      end
      W_HAVE_ADDR: if (w_hs)  w_nxt = W_RESP;
      W_HAVE_DATA: if (aw_hs) w_nxt = W_RESP;
      default: if (s0_axi_bvalid && s0_axi_bready) w_nxt = W_IDLE;
    endcase
  end

  assign commit = (w_state != W_RESP) && (w_nxt == W_RESP);

  always_ff @(posedge s0_axi_aclk) begin
    if (aw_hs) awaddr_q <= s0_axi_awaddr;
    if (w_hs) begin
      wdata_q <= s0_axi_wdata;
      wstrb_q <= s0_axi_wstrb[NB-1:0];
    end
  end

  // Readys and valids are registered from the next state so they are all low in reset.
  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      w_state        <= W_IDLE;
      s0_axi_awready <= 1'b0;
      s0_axi_wready  <= 1'b0;
      s0_axi_bvalid  <= 1'b0;
      s0_axi_bresp   <= RESP_OKAY;
    end else begin
      w_state        <= w_nxt;
      s0_axi_awready <= (w_nxt == W_IDLE) || (w_nxt == W_HAVE_DATA);
      s0_axi_wready  <= (w_nxt == W_IDLE) || (w_nxt == W_HAVE_ADDR);
      s0_axi_bvalid  <= (w_nxt == W_RESP);
      if (commit) s0_axi_bresp <= w_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else if (commit && w_ok) begin
      rf[w_idx] <= byte_merge(rf[w_idx], w_data, w_strb);
      rf[3]     <= rf[3] + 1'b1;
    end
  end

  assign ar_hs  = s0_axi_arvalid & s0_axi_arready;
  assign r_diff = {1'b0, s0_axi_araddr} - {1'b0, BASE};
  assign r_idx  = r_diff[3:2];
  assign r_ok   = !r_diff[ADDR_WIDTH] && (r_diff[ADDR_WIDTH-1:4] == '0) &&
                  (r_diff[1:0] == 2'b00);

  always_comb begin
    r_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_nxt = R_DATA;
      default: if (s0_axi_rvalid && s0_axi_rready) r_nxt = R_IDLE;
    endcase
  end

  // rf is sampled before any same-edge write lands, so reads see the old value.
  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      r_state        <= R_IDLE;
      s0_axi_arready <= 1'b0;
      s0_axi_rvalid  <= 1'b0;
      s0_axi_rdata   <= '0;
      s0_axi_rresp   <= RESP_OKAY;
    end else begin
      r_state        <= r_nxt;
      s0_axi_arready <= (r_nxt == R_IDLE);
      s0_axi_rvalid  <= (r_nxt == R_DATA);
      if (ar_hs) begin
        s0_axi_rdata <= r_ok ? rf[r_idx] : '0;
        s0_axi_rresp <= r_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed and randomized bench for axil_reg_slave against a register-map model.
module tb_axil_reg_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [4:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [2:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [7:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [2:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] mreg [4];

  always #5 clk = ~clk;

  axil_reg_slave dut (
    .s0_axi_aclk(clk), .s0_axi_areset(rst),
    .s0_axi_awaddr(awaddr), .s0_axi_awvalid(awvalid), .s0_axi_awready(awready),
    .s0_axi_wdata(wdata), .s0_axi_wstrb(wstrb), .s0_axi_wvalid(wvalid), .s0_axi_wready(wready),
    .s0_axi_bresp(bresp), .s0_axi_bvalid(bvalid), .s0_axi_bready(bready),
    .s0_axi_araddr(araddr), .s0_axi_arvalid(arvalid), .s0_axi_arready(arready),
    .s0_axi_rdata(rdata), .s0_axi_rresp(rresp), .s0_axi_rvalid(rvalid), .s0_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic bit m_ok(input logic [7:0] a);
    return (a < 8'h10) && (a[1:0] == 2'b00);
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [2:0] r);
    if (m_ok(a) && a[3:2] != 2'd3) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mreg[a[3:2]][8*b +: 8] = d[8*b +: 8];
      mreg[3] = mreg[3] + 32'd1;
      r = 3'd0;
    end else begin
      r = 3'd2;
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) mreg[i] = '0;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [2:0] resp);
    int cyc;
    bit aw_done, w_done, aw_fire, w_fire;
    logic [2:0] r0;
    cyc = 0; aw_done = 0; w_done = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 64) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("aw_w_accepted", 32'(aw_done && w_done), 32'd1);
    chk("bvalid_latency", 32'(bvalid), 32'd1);
    r0 = bresp;
    for (int i = 0; i < b_dly; i++) begin
      @(posedge clk); #1;
      chk("bvalid_hold", 32'(bvalid), 32'd1);
      chk("bresp_hold", 32'(bresp), 32'(r0));
      chk("readys_in_resp", 32'({awready, wready}), 32'd0);
    end
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("bvalid_drop", 32'(bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [7:0] a, input int r_dly,
                          output logic [31:0] d, output logic [2:0] resp);
    int cyc;
    bit fired;
    cyc = 0; fired = 0;
    araddr = a; arvalid = 1'b1;
    while (!fired && cyc < 64) begin
      fired = arready;
      @(posedge clk); #1;
      cyc++;
    end
    arvalid = 1'b0;
    chk("ar_accepted", 32'(fired), 32'd1);
    chk("rvalid_latency", 32'(rvalid), 32'd1);
    d = rdata; resp = rresp;
    for (int i = 0; i < r_dly; i++) begin
      @(posedge clk); #1;
      chk("rvalid_hold", 32'(rvalid), 32'd1);
      chk("rdata_hold", rdata, d);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("rvalid_drop", 32'(rvalid), 32'd0);
  endtask

  task automatic wr_exp(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                        input int awd, input int wd, input int bd, output logic [2:0] r);
    logic [2:0] e;
    axi_write(a, d, s, awd, wd, bd, r);
    m_write(a, d, s[3:0], e);
    chk("bresp", 32'(r), 32'(e));
  endtask

  task automatic rd_exp(input logic [7:0] a, input int rd, output logic [31:0] d,
                        output logic [2:0] r);
    axi_read(a, rd, d, r);
    chk("rdata", d, m_ok(a) ? mreg[a[3:2]] : 32'd0);
    chk("rresp", 32'(r), m_ok(a) ? 32'd0 : 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  r;
    logic [31:0] d, old;
    logic [7:0]  a, ra, wa;
    logic [31:0] wd;
    logic [2:0]  e;

    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readys", 32'({awready, wready, arready}), 32'd0);
    chk("rst_valids", 32'({bvalid, rvalid}), 32'd0);
    chk("rst_resps", 32'({bresp, rresp}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("readys_after_rst", 32'({awready, wready, arready}), 32'd7);

    wr_exp(8'h04, 32'hDEADBEEF, 5'h0F, 0, 0, 0, r);
    chk("deadbeef_bresp", 32'(r), 32'd0);
    rd_exp(8'h04, 0, d, r);
    chk("deadbeef_rdata", d, 32'hDEADBEEF);
    chk("deadbeef_rresp", 32'(r), 32'd0);
    rd_exp(8'h0C, 1, d, r);
    chk("wcnt_one", d, 32'd1);

    wr_exp(8'h00, 32'h11223344, 5'h0F, 0, 0, 0, r);
    wr_exp(8'h00, 32'hAABBCCDD, 5'h05, 0, 0, 1, r);
    rd_exp(8'h00, 0, d, r);
    chk("strobe_merge", d, 32'h11BB33DD);

    wr_exp(8'h08, 32'h0000A5A5, 5'h0F, 3, 0, 4, r);
    wr_exp(8'h08, 32'h5A5A0000, 5'h0F, 0, 3, 4, r);
    rd_exp(8'h08, 0, d, r);
    rd_exp(8'h0C, 0, d, r);
    chk("wcnt_once_each", d, 32'd5);

    wr_exp(8'h0C, 32'h12345678, 5'h0F, 0, 0, 0, r);
    chk("wcnt_write_slverr", 32'(r), 32'd2);
    wr_exp(8'h10, 32'h12345678, 5'h0F, 1, 0, 0, r);
    chk("oor_write_slverr", 32'(r), 32'd2);
    rd_exp(8'h02, 0, d, r);
    chk("misaligned_rresp", 32'(r), 32'd2);
    chk("misaligned_rdata", d, 32'd0);
    rd_exp(8'h0C, 0, d, r);
    chk("wcnt_unchanged", d, 32'd5);

    // Reset while a write response is pending.
    awaddr = 8'h00; wdata = 32'hFFFFFFFF; wstrb = 5'h0F;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("pre_rst_bvalid", 32'(bvalid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
    chk("mid_rst_awready", 32'(awready), 32'd0);
    rst = 1'b0;
    m_reset();
    @(posedge clk); #1;
    chk("post_rst_awready", 32'(awready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd_exp(8'(4 * i), 0, d, r);
      chk("post_rst_zero", d, 32'd0);
    end

    // Read and write committing on the same edge.
    for (int k = 0; k < 2; k++) begin
      ra = (k == 0) ? 8'h08 : 8'h0C;
      wa = (k == 0) ? 8'h08 : 8'h00;
      wd = (k == 0) ? 32'd5 : 32'd7;
      old = mreg[ra[3:2]];
      awaddr = wa; wdata = wd; wstrb = 5'h0F; araddr = ra;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("same_edge_rvalid", 32'(rvalid), 32'd1);
      chk("same_edge_bvalid", 32'(bvalid), 32'd1);
      chk("same_edge_old_value", rdata, old);
      chk("same_edge_bresp", 32'(bresp), 32'd0);
      m_write(wa, wd, 4'hF, e);
      bready = 1'b1; rready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0; rready = 1'b0;
      chk("same_edge_drop", 32'({bvalid, rvalid}), 32'd0);
    end
    rd_exp(8'h08, 0, d, r);
    chk("same_edge_new_value", d, 32'd5);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: a = 8'h00;
        1: a = 8'h04;
        2: a = 8'h08;
        3: a = 8'h0C;
        default: a = 8'($urandom);
      endcase
      if ($urandom_range(0, 1) == 0)
        wr_exp(a, $urandom, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 2), r);
      else
        rd_exp(a, $urandom_range(0, 2), d, r);
    end
    for (int i = 0; i < 4; i++) rd_exp(8'(4 * i), 0, d, r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
